// File: rtl/priv_trap_sequencer.sv
// priv_trap_sequencer
//   Arbitrates pending exceptions and interrupts for the privileged unit and
//   sequences trap entry (drain -> flush/commit -> redirect) and xRET.
//
//   Optional feature macro: PRIV_TRAP_WFI_EN
//     Adds input wfi, output wfi_sleep and a SLEEP state that parks the
//     sequencer until an enabled interrupt is pending.
//
//   Ports
//     CLK, nRST                 clock (rising), async active-low reset
//     exc_valid                 synchronous exception flags, bit i = cause i
//     exc_pc, exc_tval          faulting PC and bad address/instruction
//     int_pending, int_enable   mip / mie
//     global_ie                 effective global interrupt enable
//     ex_mem_stall              pipeline not yet flushable
//     mret, sret                privilege-checked xRET retiring
//     tvec_base, tvec_mode      trap vector base and vectored-mode flag
//     mepc, sepc                xRET targets
//     pipe_flush                flush request (DRAIN, COMMIT)
//     trap_commit               1-cycle CSR commit pulse
//     trap_cause/is_intr/epc/tval  latched trap info, valid from COMMIT on
//     xret_commit               1-cycle mstatus restore pulse
//     insert_pc, priv_pc        1-cycle fetch redirect and its target
//     busy                      sequencer not idle
module priv_trap_sequencer #(
    parameter int XLEN      = 32,
    parameter int NUM_CAUSE = 16,
    localparam int CW       = $clog2(NUM_CAUSE)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NUM_CAUSE-1:0] exc_valid,
    input  logic [XLEN-1:0]      exc_pc,
    input  logic [XLEN-1:0]      exc_tval,
    input  logic [NUM_CAUSE-1:0] int_pending,
    input  logic [NUM_CAUSE-1:0] int_enable,
    input  logic                 global_ie,
    input  logic                 ex_mem_stall,
    input  logic                 mret,
    input  logic                 sret,
    input  logic [XLEN-1:0]      tvec_base,
    input  logic                 tvec_mode,
    input  logic [XLEN-1:0]      mepc,
    input  logic [XLEN-1:0]      sepc,
`ifdef PRIV_TRAP_WFI_EN
    input  logic                 wfi,
    output logic                 wfi_sleep,
`endif
    output logic                 pipe_flush,
    output logic                 trap_commit,
    output logic [CW-1:0]        trap_cause,
    output logic                 trap_is_intr,
    output logic [XLEN-1:0]      trap_epc,
    output logic [XLEN-1:0]      trap_tval,
    output logic                 xret_commit,
    output logic                 insert_pc,
    output logic [XLEN-1:0]      priv_pc,
    output logic                 busy
);

    // Priority tables, highest first. Causes not listed fall back to
    // lowest-index-wins below every listed cause.
    localparam int NEXC = 14;
    localparam int NINT = 6;
    localparam int EXC_PRI [NEXC] = '{3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5};
    localparam int INT_PRI [NINT] = '{11, 3, 7, 9, 1, 5};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        COMMIT   = 3'd2,
        REDIRECT = 3'd3,
        RET      = 3'd4
`ifdef PRIV_TRAP_WFI_EN
        , SLEEP  = 3'd5
`endif
    } state_t;

    state_t state;

    // Scan the fallback first, then the table from lowest to highest
    // priority so the highest listed pending cause overwrites last.
    function automatic logic [CW-1:0] pick_exc(input logic [NUM_CAUSE-1:0] v);
        logic [CW-1:0] sel;
        sel = '0;
        for (int i = NUM_CAUSE - 1; i >= 0; i--)
            if (v[i]) sel = CW'(i);
        for (int k = NEXC - 1; k >= 0; k--)
            if (EXC_PRI[k] < NUM_CAUSE && v[EXC_PRI[k]]) sel = CW'(EXC_PRI[k]);
        return sel;
    endfunction

    function automatic logic [CW-1:0] pick_int(input logic [NUM_CAUSE-1:0] v);
        logic [CW-1:0] sel;
        sel = '0;
        for (int i = NUM_CAUSE - 1; i >= 0; i--)
            if (v[i]) sel = CW'(i);
        for (int k = NINT - 1; k >= 0; k--)
            if (INT_PRI[k] < NUM_CAUSE && v[INT_PRI[k]]) sel = CW'(INT_PRI[k]);
        return sel;
    endfunction

    logic [NUM_CAUSE-1:0] int_elig;
    logic                 exc_any;
    logic                 int_any;
    logic [CW-1:0]        exc_sel;
    logic [CW-1:0]        int_sel;
    logic [XLEN-1:0]      vec_off;
    logic [XLEN-1:0]      trap_target;

    assign int_elig = int_pending & int_enable & {NUM_CAUSE{global_ie}};
    assign exc_any  = |exc_valid;
    assign int_any  = |int_elig;
    assign exc_sel  = pick_exc(exc_valid);
    assign int_sel  = pick_int(int_elig);

    // Vectored mode only offsets interrupts; the add wraps mod 2^XLEN.
    assign vec_off     = (tvec_mode && trap_is_intr) ? (XLEN'(trap_cause) << 2) : '0;
    assign trap_target = {tvec_base[XLEN-1:2], 2'b00} + vec_off;

    // Outputs are registered alongside the state: each transition writes the
    // output values belonging to the state being entered.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            pipe_flush   <= 1'b0;
            trap_commit  <= 1'b0;
            trap_cause   <= '0;
            trap_is_intr <= 1'b0;
            trap_epc     <= '0;
            trap_tval    <= '0;
            xret_commit  <= 1'b0;
            insert_pc    <= 1'b0;
            priv_pc      <= '0;
            busy         <= 1'b0;
`ifdef PRIV_TRAP_WFI_EN
            wfi_sleep    <= 1'b0;
`endif
        end else begin
            pipe_flush  <= 1'b0;
            trap_commit <= 1'b0;
            xret_commit <= 1'b0;
            insert_pc   <= 1'b0;
            priv_pc     <= '0;
            busy        <= 1'b1;
`ifdef PRIV_TRAP_WFI_EN
            wfi_sleep   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (exc_any || int_any) begin
                        // Exceptions always beat interrupts; a trap beats xRET.
                        trap_cause   <= exc_any ? exc_sel : int_sel;
                        trap_is_intr <= !exc_any;
                        trap_epc     <= exc_pc;
                        trap_tval    <= exc_any ? exc_tval : '0;
                        pipe_flush   <= 1'b1;
                        state        <= DRAIN;
                    end else if (mret || sret) begin
                        insert_pc   <= 1'b1;
                        xret_commit <= 1'b1;
                        priv_pc     <= mret ? mepc : sepc;
                        state       <= RET;
                    end
`ifdef PRIV_TRAP_WFI_EN
                    else if (wfi) begin
                        wfi_sleep <= 1'b1;
                        state     <= SLEEP;
                    end
`endif
                    else begin
                        busy <= 1'b0;
                    end
                end
                DRAIN: begin
                    pipe_flush <= 1'b1;
                    if (!ex_mem_stall) begin
                        trap_commit <= 1'b1;
                        state       <= COMMIT;
                    end
                end
                COMMIT: begin
                    insert_pc <= 1'b1;
                    priv_pc   <= trap_target;
                    state     <= REDIRECT;
                end
`ifdef PRIV_TRAP_WFI_EN
                SLEEP: begin
                    // Wake ignores global_ie; only an eligible interrupt traps.
                    if (|(int_pending & int_enable)) begin
                        if (int_any) begin
                            trap_cause   <= int_sel;
                            trap_is_intr <= 1'b1;
                            trap_epc     <= exc_pc;
                            trap_tval    <= '0;
                            pipe_flush   <= 1'b1;
                            state        <= DRAIN;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        wfi_sleep <= 1'b1;
                    end
                end
`endif
                default: begin
                    // REDIRECT and RET both last one cycle.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// tb_priv_trap_sequencer
//   Directed and randomized trap/xRET transactions checked against a
//   transaction-level model: priority lists, expected cycle timeline and
//   expected redirect target computed from the architectural rules.
module tb_priv_trap_sequencer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [15:0] exc_valid = '0;
    logic [31:0] exc_pc = '0;
    logic [31:0] exc_tval = '0;
    logic [15:0] int_pending = '0;
    logic [15:0] int_enable = '0;
    logic        global_ie = 1'b0;
    logic        ex_mem_stall = 1'b0;
    logic        mret = 1'b0;
    logic        sret = 1'b0;
    logic [31:0] tvec_base = '0;
    logic        tvec_mode = 1'b0;
    logic [31:0] mepc = '0;
    logic [31:0] sepc = '0;
    logic        pipe_flush, trap_commit, trap_is_intr, xret_commit, insert_pc, busy;
    logic [3:0]  trap_cause;
    logic [31:0] trap_epc, trap_tval, priv_pc;

    int tests = 0;
    int fails = 0;

    // Model state: last committed trap information.
    logic [3:0]  m_cause = '0;
    logic        m_intr  = 1'b0;
    logic [31:0] m_epc   = '0;
    logic [31:0] m_tval  = '0;

    int exc_ord [16] = '{3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5, 10, 14};
    int int_ord [16] = '{11, 3, 7, 9, 1, 5, 0, 2, 4, 6, 8, 10, 12, 13, 14, 15};

    priv_trap_sequencer #(.XLEN(32), .NUM_CAUSE(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .int_pending(int_pending), .int_enable(int_enable), .global_ie(global_ie),
        .ex_mem_stall(ex_mem_stall), .mret(mret), .sret(sret),
        .tvec_base(tvec_base), .tvec_mode(tvec_mode), .mepc(mepc), .sepc(sepc),
        .pipe_flush(pipe_flush), .trap_commit(trap_commit), .trap_cause(trap_cause),
        .trap_is_intr(trap_is_intr), .trap_epc(trap_epc), .trap_tval(trap_tval),
        .xret_commit(xret_commit), .insert_pc(insert_pc), .priv_pc(priv_pc), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int first_in(input logic [15:0] v, input bit intr);
        for (int k = 0; k < 16; k++) begin
            if (intr ? v[int_ord[k]] : v[exc_ord[k]]) return intr ? int_ord[k] : exc_ord[k];
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic zero_events();
        exc_valid = '0; int_pending = '0; int_enable = '0; global_ie = 1'b0;
        mret = 1'b0; sret = 1'b0; ex_mem_stall = 1'b0;
    endtask

    // Inputs outside IDLE must be ignored, so fill them with noise.
    task automatic scramble();
        exc_valid = 16'($urandom); int_pending = 16'($urandom); int_enable = 16'($urandom);
        global_ie = 1'($urandom); mret = 1'($urandom); sret = 1'($urandom);
        exc_pc = $urandom; exc_tval = $urandom; mepc = $urandom; sepc = $urandom;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
        chk({tag, ".flush"}, {31'b0, pipe_flush}, 32'd0);
        chk({tag, ".insert"}, {31'b0, insert_pc}, 32'd0);
        chk({tag, ".commit"}, {30'b0, trap_commit, xret_commit}, 32'd0);
    endtask

    task automatic check_latches(input string tag);
        chk({tag, ".cause"}, {28'b0, trap_cause}, {28'b0, m_cause});
        chk({tag, ".intr"}, {31'b0, trap_is_intr}, {31'b0, m_intr});
        chk({tag, ".epc"}, trap_epc, m_epc);
        chk({tag, ".tval"}, trap_tval, m_tval);
    endtask

    // One transaction starting with the sequencer idle.
    task automatic run_trans(input string tag,
                             input logic [15:0] ev, input logic [15:0] ip, input logic [15:0] ie,
                             input logic ge, input logic mr, input logic sr, input logic tm,
                             input logic [31:0] base, input logic [31:0] pc, input logic [31:0] tv,
                             input logic [31:0] me, input logic [31:0] se, input int stalls);
        logic [15:0] elig;
        int          cause;
        bit          intr;
        logic [31:0] target;
        @(negedge CLK);
        exc_valid = ev; int_pending = ip; int_enable = ie; global_ie = ge;
        mret = mr; sret = sr; tvec_mode = tm; tvec_base = base;
        exc_pc = pc; exc_tval = tv; mepc = me; sepc = se; ex_mem_stall = 1'($urandom);
        elig = ip & ie & {16{ge}};
        if (ev != 0 || elig != 0) begin
            intr  = (ev == 0);
            cause = intr ? first_in(elig, 1'b1) : first_in(ev, 1'b0);
            m_cause = 4'(cause); m_intr = intr; m_epc = pc; m_tval = intr ? 32'd0 : tv;
            target = {base[31:2], 2'b00} + ((tm && intr) ? 32'(cause * 4) : 32'd0);
            step();
            chk({tag, ".drain_flush"}, {31'b0, pipe_flush}, 32'd1);
            chk({tag, ".drain_busy"}, {31'b0, busy}, 32'd1);
            chk({tag, ".drain_commit"}, {31'b0, trap_commit}, 32'd0);
            for (int i = 0; i < stalls; i++) begin
                @(negedge CLK); scramble(); ex_mem_stall = 1'b1;
                step();
                chk({tag, ".stall_flush"}, {31'b0, pipe_flush}, 32'd1);
                chk({tag, ".stall_commit"}, {31'b0, trap_commit}, 32'd0);
            end
            @(negedge CLK); scramble(); ex_mem_stall = 1'b0;
            step();
            chk({tag, ".commit"}, {31'b0, trap_commit}, 32'd1);
            chk({tag, ".commit_flush"}, {31'b0, pipe_flush}, 32'd1);
            chk({tag, ".commit_insert"}, {31'b0, insert_pc}, 32'd0);
            check_latches({tag, ".commit"});
            @(negedge CLK); zero_events();
            step();
            chk({tag, ".redir_insert"}, {31'b0, insert_pc}, 32'd1);
            chk({tag, ".redir_pc"}, priv_pc, target);
            chk({tag, ".redir_commit"}, {31'b0, trap_commit}, 32'd0);
            chk({tag, ".redir_flush"}, {31'b0, pipe_flush}, 32'd0);
            step();
            check_idle({tag, ".after"});
            check_latches({tag, ".hold"});
        end else if (mr || sr) begin
            step();
            chk({tag, ".ret_insert"}, {31'b0, insert_pc}, 32'd1);
            chk({tag, ".ret_xret"}, {31'b0, xret_commit}, 32'd1);
            chk({tag, ".ret_pc"}, priv_pc, mr ? me : se);
            chk({tag, ".ret_trap"}, {30'b0, trap_commit, pipe_flush}, 32'd0);
            check_latches({tag, ".ret_hold"});
            @(negedge CLK); zero_events();
            step();
            check_idle({tag, ".after"});
        end else begin
            step();
            check_idle({tag, ".none"});
            @(negedge CLK); zero_events();
        end
    endtask

    initial begin
        logic [15:0] ev, ip, ie;
        logic [31:0] base;
        #2;
        check_idle("reset");
        check_latches("reset");
        chk("reset.pc", priv_pc, 32'd0);
        @(negedge CLK); nRST = 1'b1;
        step();
        check_idle("post_reset");

        // Directed cases.
        run_trans("exc2", 16'h0004, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h8000_0000, 32'h100, 32'h55, 32'h0, 32'h0, 0);
        run_trans("int11", 16'h0, 16'h0880, 16'h0880, 1'b1, 1'b0, 1'b0, 1'b1,
                  32'h8000_0000, 32'h200, 32'h77, 32'h0, 32'h0, 0);
        run_trans("exc_vs_mti", 16'h0008, 16'h0080, 16'h0080, 1'b1, 1'b0, 1'b0, 1'b1,
                  32'h8000_0000, 32'h300, 32'h99, 32'h0, 32'h0, 0);
        run_trans("stall5", 16'h1000, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h0000_1003, 32'h400, 32'h11, 32'h0, 32'h0, 5);
        run_trans("mret", 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0,
                  32'h0, 32'h0, 32'h0, 32'h2000, 32'h3000, 0);
        run_trans("both_ret", 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0,
                  32'h0, 32'h0, 32'h0, 32'h2400, 32'h3400, 0);
        run_trans("sret", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0,
                  32'h0, 32'h0, 32'h0, 32'h2400, 32'h3400, 0);
        run_trans("trap_over_ret", 16'h4400, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1,
                  32'h10, 32'h500, 32'h66, 32'h2400, 32'h0, 1);
        run_trans("gie_off", 16'h0, 16'h0800, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b1,
                  32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        run_trans("wrap", 16'h0, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1,
                  32'hFFFF_FFF2, 32'h600, 32'h0, 32'h0, 32'h0, 0);

        // Reset asserted mid-drain aborts with no commit.
        @(negedge CLK);
        exc_valid = 16'h0002; exc_pc = 32'hABC; ex_mem_stall = 1'b1;
        step();
        chk("rst_mid.flush", {31'b0, pipe_flush}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        m_cause = '0; m_intr = 1'b0; m_epc = '0; m_tval = '0;
        check_idle("rst_mid");
        check_latches("rst_mid");
        zero_events();
        @(negedge CLK); nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_mid.no_commit", {30'b0, trap_commit, insert_pc}, 32'd0);
        end

        // Randomized transactions.
        for (int n = 0; n < 300; n++) begin
            ev = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0;
            ip = 16'($urandom); ie = 16'($urandom & $urandom);
            base = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | $urandom) : $urandom;
            run_trans("rand", ev, ip, ie, 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), base, $urandom, $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
